// File: rtl/tact_debounce_multi_if.sv
// rtl/tact_debounce_multi_if.sv - switch/debounce signal bundle between raw inputs and filtered outputs
interface tact_debounce_multi_if #(
    parameter int CH = 4
);
    logic [CH-1:0] Tact;
    logic [CH-1:0] Out;
    logic [CH-1:0] Rise;
    logic [CH-1:0] Fall;
    logic [CH-1:0] Repeat;
    logic          Tick;

    modport master (output Tact, input Out, Rise, Fall, Repeat, Tick);
    modport slave  (input Tact, output Out, Rise, Fall, Repeat, Tick);
endinterface

// File: rtl/tact_debounce_multi.sv
// rtl/tact_debounce_multi.sv - multi-channel tact switch debounce with prescaled sampling
// Optional auto-repeat strobes are built when TACT_REPEAT_EN is defined.
module tact_debounce_multi #(
    parameter int CH    = 4,
    parameter int DIV   = 1000,
    parameter int DEPTH = 8,
    parameter int HOLD  = 500,
    parameter int RATE  = 100
) (
    input logic                  Clock,
    input logic                  Reset,
    tact_debounce_multi_if.slave bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;
    logic [CH-1:0] sync1_q, sync2_q;
    logic [CH-1:0] out_q, out_d;
    logic [CH-1:0] rise_q, rise_d;
    logic [CH-1:0] fall_q, fall_d;
    logic [CW-1:0] cnt_q [CH];
    logic [CW-1:0] cnt_d [CH];

    always_comb begin
        tick_d = (pre_q == PRE_LAST);
        pre_d  = tick_d ? '0 : pre_q + PW'(1);
    end

    // Counters only move on sample ticks; any agreeing sample restarts the run.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        if (tick_q) begin
            for (int i = 0; i < CH; i++) begin
                if (sync2_q[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            sync1_q <= bus.Tact;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Out  = out_q;
    assign bus.Rise = rise_q;
    assign bus.Fall = fall_q;
    assign bus.Tick = tick_q;

`ifdef TACT_REPEAT_EN
    localparam int RW = $clog2(HOLD + RATE + 1);
    localparam logic [RW-1:0] R_HOLD = RW'(HOLD);
    localparam logic [RW-1:0] R_LAST = RW'(HOLD + RATE - 1);

    logic [CH-1:0] repeat_q, repeat_d;
    logic [RW-1:0] rpt_q [CH];
    logic [RW-1:0] rpt_d [CH];

    // R runs 1..HOLD+RATE-1 and folds back to HOLD, so every pass through HOLD is a pulse.
    always_comb begin
        rpt_d    = rpt_q;
        repeat_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (!out_q[i]) begin
                rpt_d[i] = '0;
            end else if (tick_q) begin
                if (rpt_q[i] == R_LAST) begin
                    rpt_d[i] = R_HOLD;
                end else begin
                    rpt_d[i] = rpt_q[i] + RW'(1);
                end
                repeat_d[i] = (rpt_d[i] == R_HOLD);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            repeat_q <= '0;
            for (int i = 0; i < CH; i++) begin
                rpt_q[i] <= '0;
            end
        end else begin
            repeat_q <= repeat_d;
            rpt_q    <= rpt_d;
        end
    end

    assign bus.Repeat = repeat_q;
`else
    logic cfg_unused;
    assign cfg_unused = (HOLD > 0) ^ (RATE > 0);
    assign bus.Repeat = '0;
`endif
endmodule

// File: tb/tb_tact_debounce_multi.sv
// tb/tb_tact_debounce_multi.sv - directed checks for tact_debounce_multi (CH=2, DIV=4, DEPTH=3, HOLD=5, RATE=2)
module tb_tact_debounce_multi;
    localparam int CH = 2;
`ifdef TACT_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    int   rise_cnt = 0;
    int   fall_cnt = 0;

    tact_debounce_multi_if #(.CH(CH)) bus ();

    tact_debounce_multi #(.CH(CH), .DIV(4), .DEPTH(3), .HOLD(5), .RATE(2)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic          rst;
        logic [CH-1:0] tact;
        logic [CH-1:0] out;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic          tick;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        if (bus.Rise[0]) rise_cnt++;
        if (bus.Fall[0]) fall_cnt++;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus.Tick && n < 16);
        chk("wait_tick", 32'(bus.Tick), 32'd1);
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_rep;
        int   n;

        // Reset, then idle (ticks at 4 and 8), then channel 0 pressed before edge 9:
        // S=1 from edge 10, updates at 13/17/21 -> Out/Rise at 21.
        for (int k = 0; k < 25; k++) begin
            vecs[k].rst  = (k == 0);
            vecs[k].tact = (k >= 9) ? 2'b01 : 2'b00;
            vecs[k].tick = (k >= 4) && (k % 4 == 0);
            vecs[k].out  = (k >= 21) ? 2'b01 : 2'b00;
            vecs[k].rise = (k == 21) ? 2'b01 : 2'b00;
            vecs[k].fall = 2'b00;
        end

        Reset    = 1'b1;
        bus.Tact = '0;
        for (int k = 0; k < 25; k++) begin
            Reset    = vecs[k].rst;
            bus.Tact = vecs[k].tact;
            step();
            chk($sformatf("v%0d_out", k),    32'(bus.Out),    32'(vecs[k].out));
            chk($sformatf("v%0d_rise", k),   32'(bus.Rise),   32'(vecs[k].rise));
            chk($sformatf("v%0d_fall", k),   32'(bus.Fall),   32'(vecs[k].fall));
            chk($sformatf("v%0d_tick", k),   32'(bus.Tick),   32'(vecs[k].tick));
            chk($sformatf("v%0d_repeat", k), 32'(bus.Repeat), 32'd0);
        end

        // Bounce: toggle every tick, then a 2-tick press, must never switch.
        bus.Tact = '0;
        pulse_reset();
        rise_cnt = 0;
        fall_cnt = 0;
        for (int t = 0; t < 12; t++) begin
            wait_tick();
            bus.Tact[0] = ~bus.Tact[0];
        end
        wait_tick();
        bus.Tact[0] = 1'b1;
        wait_tick();
        wait_tick();
        bus.Tact[0] = 1'b0;
        for (int t = 0; t < 4; t++) wait_tick();
        chk("bounce_out", 32'(bus.Out), 32'd0);
        chk("bounce_rise", 32'(rise_cnt), 32'd0);
        chk("bounce_fall", 32'(fall_cnt), 32'd0);

        // Simultaneous opposite transitions on two channels.
        pulse_reset();
        bus.Tact = 2'b01;
        n = 0;
        while (!bus.Out[0] && n < 40) begin
            step();
            n++;
        end
        chk("sim_setup_out", 32'(bus.Out), 32'b01);
        bus.Tact = 2'b10;
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.Fall[0] || bus.Rise[1]) && n < 40);
        chk("sim_rise", 32'(bus.Rise), 32'b10);
        chk("sim_fall", 32'(bus.Fall), 32'b01);
        chk("sim_out", 32'(bus.Out), 32'b10);

        // Reset mid-count: two qualifying ticks, reset, then a full 3-tick run is needed.
        Reset    = 1'b1;
        bus.Tact = 2'b01;
        step();
        Reset = 1'b0;
        for (int k = 1; k <= 9; k++) step();
        chk("pre_rst_out", 32'(bus.Out), 32'd0);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_rst_out", 32'(bus.Out), 32'd0);
        chk("mid_rst_tick", 32'(bus.Tick), 32'd0);
        chk("mid_rst_rise", 32'(bus.Rise), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3) chk("post_rst_tick3", 32'(bus.Tick), 32'd0);
            if (k == 4) chk("post_rst_tick4", 32'(bus.Tick), 32'd1);
            if (k == 5) chk("post_rst_out5", 32'(bus.Out), 32'd0);
        end
        chk("post_rst_out12", 32'(bus.Out), 32'd0);
        step();
        chk("post_rst_out13", 32'(bus.Out), 32'b01);
        chk("post_rst_rise13", 32'(bus.Rise), 32'b01);

        // Hold: repeat after the 5th, 7th, 9th tick; release after the 9th
        // still lets the 11th fire before Out falls at the 12th.
        for (n = 1; n <= 16; n++) begin
            wait_tick();
            step();
            exp_rep = RPT && (n >= 5) && (n <= 11) && (n % 2 == 1);
            chk($sformatf("hold_t%0d_repeat", n), 32'(bus.Repeat[0]), 32'(exp_rep));
            chk($sformatf("hold_t%0d_fall", n), 32'(bus.Fall[0]), 32'(n == 12));
            chk($sformatf("hold_t%0d_out", n), 32'(bus.Out[0]), 32'(n < 12));
            chk($sformatf("hold_t%0d_rise", n), 32'(bus.Rise[0]), 32'd0);
            if (n == 9) bus.Tact[0] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
